// File: rtl/opll_write_queue.sv
// opll_write_queue: FIFO of CPU writes replayed to up to three jt2413 OPLL chips with per-register-type quiet gaps
// Ports: clk/reset (sync, active high), clk_en (FM chip clock enable),
//   wr_valid/wr_chip/wr_a0/wr_data (CPU write request), chip_en (per-chip enable mask),
//   cs_n/wr_n/addr/dout (chip bus), full/busy/overflow/level (queue status).
module opll_write_queue #(
    parameter int DEPTH    = 8,
    parameter int ADDR_GAP = 12,
    parameter int DATA_GAP = 84
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     wr_valid,
    input  logic [1:0]               wr_chip,
    input  logic                     wr_a0,
    input  logic [7:0]               wr_data,
    input  logic [2:0]               chip_en,
    output logic [2:0]               cs_n,
    output logic                     wr_n,
    output logic                     addr,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int GMAX = ADDR_GAP > DATA_GAP ? ADDR_GAP : DATA_GAP;
    localparam int GW   = GMAX > 0 ? $clog2(GMAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t        state, state_nx;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [10:0]   head;
    logic [3:0]    en_ext;
    logic [2:0]    cs_n_nx;
    logic          wr_n_nx, addr_nx, push, pop, fire;
    logic [7:0]    dout_nx;

    assign head   = mem[rp];
    // chip 3 maps onto the constant-zero bit, so it is always discarded
    assign en_ext = {1'b0, chip_en};
    assign full   = level == LW'(DEPTH);
    assign busy   = state != IDLE || level != '0;
    assign push   = wr_valid && !full;
    assign pop    = state == IDLE && level != '0;
    assign fire   = pop && en_ext[head[10:9]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            gap_cnt  <= '0;
            cs_n     <= 3'b111;
            wr_n     <= 1'b1;
            addr     <= 1'b0;
            dout     <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            cs_n     <= cs_n_nx;
            wr_n     <= wr_n_nx;
            addr     <= addr_nx;
            dout     <= dout_nx;
            overflow <= overflow | (wr_valid & full);
            level    <= level + LW'(push) - LW'(pop);
            if (push) begin
                mem[wp] <= {wr_chip, wr_a0, wr_data};
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end

    always_comb begin
        state_nx = state == IDLE   ? (fire ? STROBE : IDLE) :
                   state == STROBE ? (clk_en ? GAP : STROBE) :
                                     (gap_cnt == '0 ? IDLE : GAP);
    end

    // The strobe ends on the clk_en cycle; the gap counter then runs in clk_en ticks
    always_comb begin
        cs_n_nx = state_nx != STROBE ? 3'b111 : state == IDLE ? ~(3'b001 << head[10:9]) : cs_n;
        wr_n_nx = state_nx != STROBE;
        addr_nx = fire ? head[8] : addr;
        dout_nx = fire ? head[7:0] : dout;
        gap_nx  = state == STROBE && clk_en ? (addr ? GW'(DATA_GAP) : GW'(ADDR_GAP)) :
                  state == GAP && clk_en && gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt;
    end
endmodule
